// File: rtl/fpmul_lat_checker_if.sv
// fpmul_lat_checker_if
// Groups the checker's stimulus and result signals.
//   master : stimulus side (drives vin/exp_in/dut_out/clr, observes results)
//   slave  : checker side
// Signals:
//   vin           operands applied to the multiplier this cycle
//   exp_in        golden result for the operands applied this cycle
//   dut_out       multiplier result
//   clr           synchronous clear of counters and FSM
//   exp_al/vld_al golden word and valid aligned to dut_out
//   mismatch      one-cycle registered error pulse
//   smpl_cnt      compared samples (saturating)
//   err_cnt       mismatching samples (saturating)
//   first_err_idx sample index of the first mismatch
//   state         0 IDLE, 1 ARMED, 2 CHECK, 3 FAIL
interface fpmul_lat_checker_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              vin;
  logic [DATA_W-1:0] exp_in;
  logic [DATA_W-1:0] dut_out;
  logic              clr;
  logic [DATA_W-1:0] exp_al;
  logic              vld_al;
  logic              mismatch;
  logic [CNT_W-1:0]  smpl_cnt;
  logic [CNT_W-1:0]  err_cnt;
  logic [CNT_W-1:0]  first_err_idx;
  logic [1:0]        state;

  modport master (
    output vin, exp_in, dut_out, clr,
    input  exp_al, vld_al, mismatch, smpl_cnt, err_cnt, first_err_idx, state
  );

  modport slave (
    input  vin, exp_in, dut_out, clr,
    output exp_al, vld_al, mismatch, smpl_cnt, err_cnt, first_err_idx, state
  );
endinterface

// File: rtl/fpmul_lat_checker.sv
// fpmul_lat_checker
// Latency-aligned result checker for a pipelined FP multiplier. The golden
// word and its valid travel through LATENCY registers so they line up with
// the multiplier output; every aligned sample is compared and counted.
// Ports:
//   clk_i    rising-edge clock
//   rst_n_i  asynchronous active-low reset
//   chk      fpmul_lat_checker_if.slave (stimulus in, results out)
// Build option:
//   CHK_NAN_EQ_EN  when defined, two NaN words (binary32 layout) compare
//                  equal regardless of sign and payload; otherwise the
//                  compare is bitwise over DATA_W bits.
//
// state | meaning
// IDLE  | waiting for the first launched sample
// ARMED | samples launched, none compared yet
// CHECK | at least one sample compared, all matched
// FAIL  | a mismatch was seen; sticky until clr or reset
module fpmul_lat_checker #(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  fpmul_lat_checker_if.slave chk
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_CHECK = 2'd2,
    ST_FAIL  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [LATENCY-1:0] vld_q;
  logic [DATA_W-1:0]  exp_q [LATENCY];

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   smpl_q, smpl_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   fe_q, fe_d;
  logic               mm_q, mm_d;

  logic [DATA_W-1:0]  exp_al;
  logic               vld_al;
  logic               words_eq;

  assign exp_al = exp_q[LATENCY-1];
  assign vld_al = vld_q[LATENCY-1];

`ifdef CHK_NAN_EQ_EN
  // binary32 layout: exponent all ones and nonzero mantissa
  function automatic logic is_nan(input logic [DATA_W-1:0] w);
    return (&w[DATA_W-2 -: 8]) && (|w[DATA_W-10:0]);
  endfunction

  assign words_eq = (chk.dut_out == exp_al) ||
                    (is_nan(chk.dut_out) && is_nan(exp_al));
`else
  assign words_eq = (chk.dut_out == exp_al);
`endif

  // Delay line: not touched by clr, only by reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) exp_q[i] <= '0;
    end else begin
      vld_q[0] <= chk.vin;
      exp_q[0] <= chk.exp_in;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        exp_q[i] <= exp_q[i-1];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    smpl_d  = smpl_q;
    err_d   = err_q;
    fe_d    = fe_q;
    mm_d    = 1'b0;

    if (chk.clr) begin
      // clr overrides any compare happening in the same cycle
      smpl_d  = '0;
      err_d   = '0;
      fe_d    = '0;
      state_d = chk.vin ? ST_ARMED : ST_IDLE;
    end else begin
      if (vld_al) begin
        if (smpl_q != CNT_MAX) smpl_d = smpl_q + 1'b1;
        if (!words_eq) begin
          mm_d = 1'b1;
          if (err_q != CNT_MAX) err_d = err_q + 1'b1;
          // err_q is zero only until the first mismatch since clear/reset
          if (err_q == '0) fe_d = smpl_q;
        end
      end

      unique case (state_q)
        ST_IDLE:  if (chk.vin) state_d = ST_ARMED;
        ST_ARMED: if (vld_al)  state_d = words_eq ? ST_CHECK : ST_FAIL;
        ST_CHECK: if (vld_al && !words_eq) state_d = ST_FAIL;
        ST_FAIL:  state_d = ST_FAIL;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      smpl_q  <= '0;
      err_q   <= '0;
      fe_q    <= '0;
      mm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      smpl_q  <= smpl_d;
      err_q   <= err_d;
      fe_q    <= fe_d;
      mm_q    <= mm_d;
    end
  end

  assign chk.exp_al        = exp_al;
  assign chk.vld_al        = vld_al;
  assign chk.mismatch      = mm_q;
  assign chk.smpl_cnt      = smpl_q;
  assign chk.err_cnt       = err_q;
  assign chk.first_err_idx = fe_q;
  assign chk.state         = state_q;

endmodule

// File: tb/tb_fpmul_lat_checker.sv
module tb_fpmul_lat_checker;
  localparam int LAT = 4;

`ifdef CHK_NAN_EQ_EN
  localparam logic [31:0] NAN_ERR = 32'd0;
  localparam logic [31:0] NAN_ST  = 32'd2;
`else
  localparam logic [31:0] NAN_ERR = 32'd1;
  localparam logic [31:0] NAN_ST  = 32'd3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  fpmul_lat_checker_if #(.DATA_W(32), .CNT_W(16)) u_if ();
  fpmul_lat_checker_if #(.DATA_W(32), .CNT_W(4))  u_if2 ();

  fpmul_lat_checker #(.DATA_W(32), .LATENCY(LAT), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .chk(u_if)
  );
  fpmul_lat_checker #(.DATA_W(32), .LATENCY(LAT), .CNT_W(4)) u_dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .chk(u_if2)
  );

  always #5 clk = ~clk;

  logic [31:0] vec [32];
  logic [31:0] dvec [32];
  logic [31:0] s_vld [64], s_exp [64], s_mm [64], s_smpl [64];
  logic [31:0] s_err [64], s_fe [64], s_st [64];
  logic [31:0] r_vld, r_exp, r_mm, r_smpl, r_err, r_st, r_fe, pre_smpl;
  int pulses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n, input int bad_idx);
    for (int i = 0; i < n; i++) begin
      vec[i]  = 32'h3F80_0000 + i * 32'h0001_0203;
      dvec[i] = vec[i] ^ ((i == bad_idx) ? 32'h1 : 32'h0);
    end
  endtask

  task automatic snap(input int k);
    s_vld[k]  = 32'(u_if.vld_al);
    s_exp[k]  = u_if.exp_al;
    s_mm[k]   = 32'(u_if.mismatch);
    s_smpl[k] = 32'(u_if.smpl_cnt);
    s_err[k]  = 32'(u_if.err_cnt);
    s_fe[k]   = 32'(u_if.first_err_idx);
    s_st[k]   = 32'(u_if.state);
  endtask

  // Cycle k starts 1 time unit after a rising edge; snapshot then drive.
  task automatic run_stream(input int n, input int clr_k, input int rst_k);
    for (int k = 0; k <= n + LAT + 1; k++) begin
      snap(k);
      u_if.vin     = (k < n);
      u_if.exp_in  = (k < n) ? vec[k] : 32'h0;
      u_if.dut_out = (k >= LAT && k - LAT < n) ? dvec[k-LAT] : 32'h0;
      u_if.clr     = (k == clr_k);
      if (k == rst_k) begin
        pre_smpl = 32'(u_if.smpl_cnt);
        rst_n = 1'b0;
        #1;
        r_vld  = 32'(u_if.vld_al);
        r_exp  = u_if.exp_al;
        r_mm   = 32'(u_if.mismatch);
        r_smpl = 32'(u_if.smpl_cnt);
        r_err  = 32'(u_if.err_cnt);
        r_st   = 32'(u_if.state);
        r_fe   = 32'(u_if.first_err_idx);
        #1;
        rst_n = 1'b1;
      end
      step();
    end
    u_if.vin = 1'b0; u_if.clr = 1'b0; u_if.exp_in = '0; u_if.dut_out = '0;
  endtask

  task automatic do_clr(input logic v);
    u_if.clr = 1'b1; u_if.vin = v; u_if.exp_in = '0; u_if.dut_out = '0;
    step();
    u_if.clr = 1'b0; u_if.vin = 1'b0;
  endtask

  initial begin
    u_if.vin = 0;  u_if.exp_in = '0;  u_if.dut_out = '0;  u_if.clr = 0;
    u_if2.vin = 0; u_if2.exp_in = '0; u_if2.dut_out = '0; u_if2.clr = 0;

    // reset state
    #12;
    check("rst_vld", 32'(u_if.vld_al), 32'd0);
    check("rst_exp", u_if.exp_al, 32'd0);
    check("rst_smpl", 32'(u_if.smpl_cnt), 32'd0);
    check("rst_state", 32'(u_if.state), 32'd0);
    check("rst_mm", 32'(u_if.mismatch), 32'd0);
    rst_n = 1'b1;
    step();

    // clean 10-sample stream
    fill(10, -1);
    run_stream(10, -1, -1);
    check("t1_armed", s_st[1], 32'd1);
    check("t1_vld3", s_vld[3], 32'd0);
    check("t1_vld4", s_vld[4], 32'd1);
    check("t1_exp4", s_exp[4], vec[0]);
    check("t1_state5", s_st[5], 32'd2);
    check("t1_vld13", s_vld[13], 32'd1);
    check("t1_vld14", s_vld[14], 32'd0);
    check("t1_smpl", s_smpl[15], 32'd10);
    check("t1_err", s_err[15], 32'd0);
    check("t1_state", s_st[15], 32'd2);
    do_clr(1'b0);
    check("clr_smpl", 32'(u_if.smpl_cnt), 32'd0);
    check("clr_state", 32'(u_if.state), 32'd0);

    // sample 3 corrupted
    fill(10, 3);
    run_stream(10, -1, -1);
    check("t2_mm7", s_mm[7], 32'd0);
    check("t2_mm8", s_mm[8], 32'd1);
    check("t2_mm9", s_mm[9], 32'd0);
    pulses = 0;
    for (int i = 0; i <= 15; i++) pulses += int'(s_mm[i]);
    check("t2_pulses", 32'(pulses), 32'd1);
    check("t2_st7", s_st[7], 32'd2);
    check("t2_st8", s_st[8], 32'd3);
    check("t2_smpl", s_smpl[15], 32'd10);
    check("t2_err", s_err[15], 32'd1);
    check("t2_first", s_fe[15], 32'd3);
    check("t2_state", s_st[15], 32'd3);
    do_clr(1'b0);
    check("clr2_err", 32'(u_if.err_cnt), 32'd0);
    check("clr2_first", 32'(u_if.first_err_idx), 32'd0);
    check("clr2_state", 32'(u_if.state), 32'd0);

    // clr in the cycle of a mismatch
    fill(4, 3);
    run_stream(4, 7, -1);
    check("t4_smpl7", s_smpl[7], 32'd3);
    check("t4_err8", s_err[8], 32'd0);
    check("t4_mm8", s_mm[8], 32'd0);
    check("t4_st8", s_st[8], 32'd0);
    check("t4_smpl8", s_smpl[8], 32'd0);

    // clr together with vin arms the FSM
    do_clr(1'b1);
    check("clrvin_state", 32'(u_if.state), 32'd1);
    repeat (LAT) step();
    check("clrvin_smpl", 32'(u_if.smpl_cnt), 32'd1);
    check("clrvin_check", 32'(u_if.state), 32'd2);
    do_clr(1'b0);

    // NaN vs NaN with differing sign and payload
    vec[0]  = 32'h7FC0_0000;
    dvec[0] = 32'hFFC0_0001;
    run_stream(1, -1, -1);
    check("nan_mm", s_mm[5], NAN_ERR);
    check("nan_err", s_err[6], NAN_ERR);
    check("nan_state", s_st[6], NAN_ST);

    // reset pulse during cycle 2 of a 10-sample stream
    fill(10, -1);
    run_stream(10, -1, 2);
    check("r_pre_smpl", pre_smpl, 32'd1);
    check("r_vld", r_vld, 32'd0);
    check("r_exp", r_exp, 32'd0);
    check("r_mm", r_mm, 32'd0);
    check("r_smpl", r_smpl, 32'd0);
    check("r_err", r_err, 32'd0);
    check("r_fe", r_fe, 32'd0);
    check("r_state", r_st, 32'd0);
    check("r_vld5", s_vld[5], 32'd0);
    check("r_vld6", s_vld[6], 32'd1);
    check("r_smpl_end", s_smpl[15], 32'd8);
    check("r_err_end", s_err[15], 32'd0);
    check("r_state_end", s_st[15], 32'd2);

    // saturation on the CNT_W=4 instance: 20 mismatching samples
    for (int k = 0; k <= 20 + LAT; k++) begin
      u_if2.vin     = (k < 20);
      u_if2.exp_in  = 32'(k);
      u_if2.dut_out = 32'hFFFF_FFFF;
      if (k == 19) check("sat_smpl15", 32'(u_if2.smpl_cnt), 32'd15);
      step();
    end
    u_if2.vin = 1'b0;
    check("sat_smpl", 32'(u_if2.smpl_cnt), 32'd15);
    check("sat_err", 32'(u_if2.err_cnt), 32'd15);
    check("sat_first", 32'(u_if2.first_err_idx), 32'd0);
    check("sat_state", 32'(u_if2.state), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fpmul_lat_checker.md
FPMUL_LAT_CHECKER -- requirements
Module: fpmul_lat_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of operand/result words.
REQ-002 SHALL have parameter LATENCY, default 4, DUT pipeline depth in cycles; legal range 1..16.
REQ-003 SHALL have parameter CNT_W, default 16, width of all counters.
REQ-004 SHALL have port CLK  in  1  rising-edge clock (one clock domain).
REQ-005 SHALL have port RST_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port VIN  in  1  operands applied to DUT this cycle.
REQ-007 SHALL have port EXP_IN  in  DATA_W  golden result for operands applied this cycle.
REQ-008 SHALL have port DUT_OUT  in  DATA_W  DUT result.
REQ-009 SHALL have port CLR  in  1  synchronous clear of counters and FSM.
REQ-010 SHALL have port EXP_AL  out  DATA_W  expected word aligned to DUT_OUT.
REQ-011 SHALL have port VLD_AL  out  1  aligned valid.
REQ-012 SHALL have port MISMATCH  out  1  one-cycle registered error pulse.
REQ-013 SHALL have port SMPL_CNT  out  CNT_W  compared samples.
REQ-014 SHALL have port ERR_CNT  out  CNT_W  mismatching samples.
REQ-015 SHALL have port FIRST_ERR_IDX  out  CNT_W  sample index of first mismatch.
REQ-016 SHALL have port STATE  out  2  FSM state: 0 IDLE, 1 ARMED, 2 CHECK, 3 FAIL.

Function
REQ-017 SHALL delay {VIN, EXP_IN} through exactly LATENCY registers; EXP_AL/VLD_AL are the last stage.
REQ-018 SHALL compare DUT_OUT with EXP_AL in every cycle where VLD_AL=1; no compare when VLD_AL=0.
REQ-019 SHALL register compare results at the next edge: SMPL_CNT+1; on inequality ERR_CNT+1 and MISMATCH=1 for one cycle.
REQ-020 SHALL saturate SMPL_CNT and ERR_CNT at all-ones; no wrap-around.
REQ-021 SHALL load FIRST_ERR_IDX with pre-increment SMPL_CNT on the first mismatch only; hold thereafter.
REQ-022 FSM: IDLE->ARMED on VIN=1; ARMED->CHECK on first VLD_AL=1; CHECK->FAIL on mismatch; FAIL sticky; a first-sample mismatch goes ARMED->FAIL directly.
REQ-023 CLR=1 SHALL zero counters, FIRST_ERR_IDX, MISMATCH and force IDLE; delay line not flushed; compare in CLR cycle discarded; CLR wins over simultaneous mismatch.
REQ-024 VIN=1 in the CLR cycle SHALL move FSM to ARMED at the next edge instead of IDLE.
REQ-025 Back-to-back VIN every cycle SHALL be checked with no bubbles; throughput one sample/cycle.

Reset
REQ-026 RST_n=0 SHALL asynchronously clear delay line, EXP_AL=0, VLD_AL=0, MISMATCH=0, all counters=0, FIRST_ERR_IDX=0, STATE=IDLE.
REQ-027 Reset mid-stream SHALL discard all in-flight samples; no compare occurs for samples launched before RST_n release.

Configuration
REQ-028 With macro CHK_NAN_EQ_EN defined, two words both NaN (DATA_W=32: exponent 0xFF, mantissa nonzero) SHALL compare equal regardless of sign and payload.
REQ-029 Without CHK_NAN_EQ_EN, comparison SHALL be bitwise equality over DATA_W bits.

Verification
REQ-030 LATENCY=4, VIN=1 cycles 0..9, DUT_OUT=EXP_AL always -> VLD_AL first high cycle 4, SMPL_CNT=10, ERR_CNT=0, STATE=CHECK.
REQ-031 Same stream, sample 3 corrupted (bit 0 flipped) -> one MISMATCH pulse, ERR_CNT=1, FIRST_ERR_IDX=3, STATE=FAIL.
REQ-032 CNT_W=4, 20 mismatching samples -> ERR_CNT and SMPL_CNT hold 15.
REQ-033 CLR asserted on the cycle of a mismatch -> ERR_CNT=0, MISMATCH=0, STATE=IDLE next cycle.
REQ-034 EXP_AL=0x7FC00000, DUT_OUT=0xFFC00001 -> no mismatch with CHK_NAN_EQ_EN, ERR_CNT=1 without.
REQ-035 RST_n pulsed low at cycle 2 of a 10-sample stream -> all outputs zero asynchronously, SMPL_CNT counts only samples launched after release.
